// File: rtl/ck_pkg.sv
// Shared constants and helpers for the CSA control-word generator and its checker.
package ck_pkg;

  localparam int unsigned AXI_DATA_WIDTH    = 32;
  localparam int unsigned CSA_CALC_IN_WIDTH = 40;
  localparam int unsigned CYPHER_DATA_WIDTH = 64;
  localparam int unsigned CB_SIG_BYTES      = 6;
  localparam int unsigned ERR_WIDTH         = 3;

  // Byte-XOR constants applied to each significant cb byte.
  localparam logic [7:0] CK_K0 = 8'hB5;
  localparam logic [7:0] CK_K1 = 8'h93;
  localparam logic [7:0] CK_K2 = 8'h5E;
  localparam logic [7:0] CK_K3 = 8'hD6;
  localparam logic [7:0] CK_K4 = 8'hB0;
  localparam logic [7:0] CK_K5 = 8'hD7;

  localparam logic [7:0] CK_K [CB_SIG_BYTES] = '{CK_K0, CK_K1, CK_K2, CK_K3, CK_K4, CK_K5};

  // CK byte that carries cb byte j; bytes 3 and 7 are checksums.
  localparam logic [2:0] CK_SRC [CB_SIG_BYTES] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

  // Error-code bit positions.
  localparam int unsigned ERR_B3 = 0;
  localparam int unsigned ERR_B7 = 1;
  localparam int unsigned ERR_B6 = 2;

  // Select byte idx of a CK word.
  function automatic logic [7:0] ck_byte(input logic [CYPHER_DATA_WIDTH-1:0] ck,
                                         input logic [2:0] idx);
    return ck[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ck_byte_unmix.sv
// Undo one generator byte transform: (b - L) ^ K, all mod 256.
module ck_byte_unmix (
  input  logic [7:0] b_i,
  input  logic [7:0] l_i,
  input  logic [7:0] k_i,
  output logic [7:0] y_o
);

  // Subtract the loop byte, then strip the per-byte XOR constant.
  assign y_o = 8'(b_i - l_i) ^ k_i;

endmodule

// File: rtl/ck_recoverer.sv
// Checks CK checksum bytes and recovers the seed (loops==0) or the 48 cb bits (loops!=0).
module ck_recoverer
  import ck_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CYPHER_DATA_WIDTH-1:0]  s_ck,
  input  logic [AXI_DATA_WIDTH-1:0]     s_loops,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CSA_CALC_IN_WIDTH-1:0]  m_in,
  output logic [CYPHER_DATA_WIDTH-1:0]  m_cb,
  output logic [AXI_DATA_WIDTH-1:0]     m_loops,
  output logic                          m_ok,
  output logic [ERR_WIDTH-1:0]          m_err_code,
  input  logic                          clear_stats,
  output logic [AXI_DATA_WIDTH-1:0]     ok_count,
  output logic [AXI_DATA_WIDTH-1:0]     err_count,
  output logic                          first_err_vld,
  output logic [CYPHER_DATA_WIDTH-1:0]  first_err_ck
);

  localparam logic [AXI_DATA_WIDTH-1:0] CNT_MAX = '1;

  logic                          en_c;
  logic                          s1_vld_q;
  logic [CYPHER_DATA_WIDTH-1:0]  s1_ck_q;
  logic [AXI_DATA_WIDTH-1:0]     s1_loops_q;
  logic [7:0]                    s1_sum_lo_q;
  logic [7:0]                    s1_sum_hi_q;

  logic                          m_valid_q;
  logic [CSA_CALC_IN_WIDTH-1:0]  m_in_q;
  logic [CYPHER_DATA_WIDTH-1:0]  m_cb_q;
  logic [AXI_DATA_WIDTH-1:0]     m_loops_q;
  logic                          m_ok_q;
  logic [ERR_WIDTH-1:0]          m_err_q;
  logic [CYPHER_DATA_WIDTH-1:0]  m_ck_q;

  logic [7:0]                    cb_byte_c [CB_SIG_BYTES];
  logic                          loops_zero_c;
  logic [ERR_WIDTH-1:0]          err_c;
  logic [CSA_CALC_IN_WIDTH-1:0]  in_c;
  logic [CYPHER_DATA_WIDTH-1:0]  cb_c;

  logic [AXI_DATA_WIDTH-1:0]     ok_count_q, ok_count_d;
  logic [AXI_DATA_WIDTH-1:0]     err_count_q, err_count_d;
  logic                          first_err_vld_q, first_err_vld_d;
  logic [CYPHER_DATA_WIDTH-1:0]  first_err_ck_q, first_err_ck_d;

  // Both stages move together whenever the output slot is free or being drained.
  assign en_c    = !m_valid_q || m_ready;
  assign s_ready = en_c;

  // Six byte unmixers recover the significant cb bytes from the S1 word.
  for (genvar j = 0; j < CB_SIG_BYTES; j++) begin : g_unmix
    ck_byte_unmix u_unmix (
      .b_i (ck_byte(s1_ck_q, CK_SRC[j])),
      .l_i (s1_loops_q[7:0]),
      .k_i (CK_K[j]),
      .y_o (cb_byte_c[j])
    );
  end

  // S2 checks and result selection.
  always_comb begin
    loops_zero_c   = (s1_loops_q == '0);
    err_c          = '0;
    err_c[ERR_B3]  = ck_byte(s1_ck_q, 3'd3) != s1_sum_lo_q;
    err_c[ERR_B7]  = ck_byte(s1_ck_q, 3'd7) != s1_sum_hi_q;
    err_c[ERR_B6]  = loops_zero_c && (ck_byte(s1_ck_q, 3'd6) != 8'h00);
    in_c           = '0;
    cb_c           = '0;
    if (loops_zero_c) begin
      in_c = {ck_byte(s1_ck_q, 3'd5), ck_byte(s1_ck_q, 3'd4), ck_byte(s1_ck_q, 3'd2),
              ck_byte(s1_ck_q, 3'd1), ck_byte(s1_ck_q, 3'd0)};
    end else begin
      cb_c = {16'h0000, cb_byte_c[5], cb_byte_c[4], cb_byte_c[3],
              cb_byte_c[2], cb_byte_c[1], cb_byte_c[0]};
    end
  end

  // Two-stage pipeline: S1 captures the word and checksum sums, S2 holds the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_ck_q     <= '0;
      s1_loops_q  <= '0;
      s1_sum_lo_q <= '0;
      s1_sum_hi_q <= '0;
      m_valid_q   <= 1'b0;
      m_in_q      <= '0;
      m_cb_q      <= '0;
      m_loops_q   <= '0;
      m_ok_q      <= 1'b0;
      m_err_q     <= '0;
      m_ck_q      <= '0;
    end else if (en_c) begin
      s1_vld_q    <= s_valid;
      s1_ck_q     <= s_ck;
      s1_loops_q  <= s_loops;
      s1_sum_lo_q <= 8'(ck_byte(s_ck, 3'd0) + ck_byte(s_ck, 3'd1) + ck_byte(s_ck, 3'd2));
      s1_sum_hi_q <= 8'(ck_byte(s_ck, 3'd4) + ck_byte(s_ck, 3'd5) + ck_byte(s_ck, 3'd6));
      m_valid_q   <= s1_vld_q;
      m_in_q      <= in_c;
      m_cb_q      <= cb_c;
      m_loops_q   <= s1_loops_q;
      m_ok_q      <= (err_c == '0);
      m_err_q     <= err_c;
      m_ck_q      <= s1_ck_q;
    end
  end

  // Statistics next-state: clear beats a same-cycle delivery.
  always_comb begin
    ok_count_d      = ok_count_q;
    err_count_d     = err_count_q;
    first_err_vld_d = first_err_vld_q;
    first_err_ck_d  = first_err_ck_q;
    if (clear_stats) begin
      ok_count_d      = '0;
      err_count_d     = '0;
      first_err_vld_d = 1'b0;
      first_err_ck_d  = '0;
    end else if (m_valid_q && m_ready) begin
      if (m_ok_q) begin
        if (ok_count_q != CNT_MAX) ok_count_d = ok_count_q + 32'd1;
      end else begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 32'd1;
        if (!first_err_vld_q) begin
          first_err_vld_d = 1'b1;
          first_err_ck_d  = m_ck_q;
        end
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_count_q      <= '0;
      err_count_q     <= '0;
      first_err_vld_q <= 1'b0;
      first_err_ck_q  <= '0;
    end else begin
      ok_count_q      <= ok_count_d;
      err_count_q     <= err_count_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_ck_q  <= first_err_ck_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_in          = m_in_q;
  assign m_cb          = m_cb_q;
  assign m_loops       = m_loops_q;
  assign m_ok          = m_ok_q;
  assign m_err_code    = m_err_q;
  assign ok_count      = ok_count_q;
  assign err_count     = err_count_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_ck  = first_err_ck_q;

endmodule
